// File: rtl/cra_pkg.sv
// Shared constants, FSM encoding and the width-check macro for the digit-serial adder sequencer.
`ifndef CRA_PKG_SV
`define CRA_PKG_SV

// Elaboration-time guard: operand width must be a non-zero multiple of the slice width.
`define CRA_WIDTH_CHECK(w) \
  if (((w) % 4) != 0 || (w) < 4) begin : g_width_bad \
    $error("cra: width must be a multiple of 4 and at least 4"); \
  end

package cra_pkg;

  localparam int CRA_SLICE = 4;

  typedef enum logic [1:0] {
    CRA_IDLE = 2'd0,
    CRA_RUN  = 2'd1,
    CRA_DONE = 2'd2
  } cra_state_e;

endpackage

`endif

// File: rtl/cra4bits.sv
// 4-bit carry-ripple adder slice; the shared datapath of cra_seq_ctrl.
module cra4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/cra_seq_ctrl.sv
// Digit-serial adder: one 4-bit slice per clock, LSB slice first, carry held in c_q.
// Optional macro CRA_SEQ_OVF_EN adds the two's-complement overflow output ovf.
module cra_seq_ctrl
  import cra_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         busy
`ifdef CRA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int K  = n / CRA_SLICE;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  `CRA_WIDTH_CHECK(n)

  cra_state_e      state;
  logic [IW-1:0]   idx;
  logic [IW+1:0]   base;
  logic            c_q;
  logic [n-1:0]    a_q;
  logic [n-1:0]    b_q;
  logic [n-1:0]    s_q;
  logic [3:0]      sl_s;
  logic            sl_cout;

  // Bit offset of the active slice (idx * 4).
  assign base = {idx, 2'b00};

  cra4bits u_slice (
    .a    (a_q[base +: CRA_SLICE]),
    .b    (b_q[base +: CRA_SLICE]),
    .cin  (c_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CRA_IDLE;
      idx   <= '0;
      c_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
    end else begin
      case (state)
        CRA_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= cin;
            idx   <= '0;
            s_q   <= '0;
            state <= CRA_RUN;
          end
        end
        CRA_RUN: begin
          s_q[base +: CRA_SLICE] <= sl_s;
          c_q                    <= sl_cout;
          if (idx == LAST) state <= CRA_DONE;
          else             idx   <= idx + 1'b1;
        end
        CRA_DONE: begin
          if (out_ready) state <= CRA_IDLE;
        end
        default: state <= CRA_IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is asserted, even though state already reads IDLE.
  assign in_ready  = rst_n && (state == CRA_IDLE);
  assign busy      = (state == CRA_RUN);
  assign out_valid = (state == CRA_DONE);
  assign s         = s_q;
  assign cout      = c_q;

`ifdef CRA_SEQ_OVF_EN
  assign ovf = (a_q[n-1] == b_q[n-1]) && (s_q[n-1] != a_q[n-1]);
`endif

endmodule

// File: tb/tb_cra_seq_ctrl.sv
// Self-checking bench for cra_seq_ctrl (n=16): vector table plus handshake/reset corner sequences.
`timescale 1ns/1ps
module tb_cra_seq_ctrl;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         cin_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         busy;
`ifdef CRA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cra_seq_ctrl #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin_i),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
`ifdef CRA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tab [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it; all sampling and driving happens here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE with out_ready=1: checks latency, busy length and result.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    a_i = v.a; b_i = v.b; cin_i = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      busy_cnt += int'(busy);
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, ".s"}, 32'(s), 32'(v.s));
    check({tag, ".cout"}, 32'(cout), 32'(v.cout));
`ifdef CRA_SEQ_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(v.ovf));
`endif
    step();
    check({tag, ".released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cyc [3];
    int acc_j;
    int res_j;
    int cyc;

    //            a        b        cin   s        cout  ovf
    tab[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tab[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tab[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tab[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tab[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tab[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    tab[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tab[7] = '{16'h89AB, 16'h7654, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tab[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cin_i = 1'b0; a_i = '0; b_i = '0;

    // Reset state
    step(); step();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.s", 32'(s), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
`ifdef CRA_SEQ_OVF_EN
    check("rst.ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) do_op(tab[i], $sformatf("vec%0d", i));

    // Backpressure: result held, new request ignored in DONE, then a different request accepted.
    a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp.out_valid", 32'(out_valid), 32'd1);
    a_i = 16'hAAAA; b_i = 16'h5555; cin_i = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp.hold%0d.s", i), 32'(s), 32'h3333);
      check($sformatf("bp.hold%0d.cout", i), 32'(cout), 32'd0);
      check($sformatf("bp.hold%0d.in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp.hold%0d.out_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp.idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    do_op('{16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0}, "bp.next");

    // Reset while idx==2 of 0xABCD+0x1111 aborts the operation.
    a_i = 16'hABCD; b_i = 16'h1111; cin_i = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.s", 32'(s), 32'd0);
    check("mid.cout", 32'(cout), 32'd0);
    check("mid.in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid.in_ready", 32'(in_ready), 32'd1);
    step(); step(); step(); step(); step();
    check("mid.no_result", 32'(out_valid), 32'd0);
    do_op(tab[8], "mid.next");

    // Reset in DONE drops the pending result.
    a_i = 16'h00FF; b_i = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("done.out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("done.rst_out_valid", 32'(out_valid), 32'd0);
    check("done.rst_s", 32'(s), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;

    // Back-to-back with in_valid and out_ready held high: accepts every K+2 = 6 cycles.
    acc_j = 0; res_j = 0; cyc = 0;
    in_valid = 1'b1;
    a_i = tab[0].a; b_i = tab[0].b; cin_i = tab[0].cin;
    while (cyc < 40) begin
      if (out_valid && res_j < 3) begin
        check($sformatf("b2b%0d.s", res_j), 32'(s), 32'(tab[res_j].s));
        check($sformatf("b2b%0d.cout", res_j), 32'(cout), 32'(tab[res_j].cout));
        res_j++;
      end
      if (in_ready) begin
        if (acc_j < 3) begin
          a_i = tab[acc_j].a; b_i = tab[acc_j].b; cin_i = tab[acc_j].cin;
          acc_cyc[acc_j] = cyc;
          acc_j++;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    check("b2b.accepts", 32'(acc_j), 32'd3);
    check("b2b.results", 32'(res_j), 32'd3);
    if (acc_j == 3) begin
      check("b2b.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
